// File: rtl/inv_sqrt_nr.sv
// Handshaked fixed-point 1/sqrt(x): even-shift range reduction, linear seed,
// NR_ITERS Newton-Raphson steps on one shared multiplier, exact power-of-two rescale.
module inv_sqrt_nr #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 24,
   parameter int NR_ITERS  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] inv_sqrt,
   output logic             out_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] NORM   = 3'd1;
   localparam logic [2:0] SEED   = 3'd2;
   localparam logic [2:0] MUL_SQ = 3'd3;
   localparam logic [2:0] MUL_X  = 3'd4;
   localparam logic [2:0] MUL_Y  = 3'd5;
   localparam logic [2:0] SCALE  = 3'd6;
   localparam logic [2:0] DONE   = 3'd7;

   localparam logic [WIDTH-1:0] C0 = WIDTH'($rtoi(1.41421356 * (2.0 ** FRAC_BITS) + 0.5));
   localparam logic [WIDTH-1:0] C1 = WIDTH'($rtoi(0.275 * (2.0 ** FRAC_BITS) + 0.5));
   localparam logic [WIDTH-1:0] FP_ONE     = WIDTH'(1) << FRAC_BITS;
   localparam logic [WIDTH-1:0] THREE_HALF = WIDTH'(3) << (FRAC_BITS - 1);
   localparam logic [2:0]       LAST_ITER  = 3'(NR_ITERS - 1);

   logic [2:0]        state;
   logic [WIDTH-1:0]  x_r, xn, y, t;
   logic signed [7:0] k;
   logic              zero;
   logic [2:0]        iter;

   logic [WIDTH-1:0]    mul_a, mul_b, mres;
   logic [2*WIDTH-1:0]  prod;
   logic signed [7:0]   k_norm;
   logic [7:0]          sh_norm, sh_scale;
   logic [WIDTH-1:0]    xn_norm, r_scale;
   logic [WIDTH+15:0]   wide;
   logic                sat;

   function automatic logic [7:0] lead_one(input logic [WIDTH-1:0] v);
      lead_one = 8'd0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) lead_one = 8'(i);
      end
   endfunction

   // Shared multiplier operand selection; result keeps the same Q format by truncation
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         SEED:    begin mul_a = xn; mul_b = C1; end
         MUL_SQ:  begin mul_a = y;  mul_b = y;  end
         MUL_X:   begin mul_a = t;  mul_b = xn; end
         MUL_Y:   begin mul_a = y;  mul_b = THREE_HALF - (t >> 1); end
         default: begin mul_a = '0; mul_b = '0; end
      endcase
      prod = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
      mres = prod[FRAC_BITS +: WIDTH];
   end

   // Range reduction by an even shift (2k) and the matching rescale by k
   always_comb begin
      k_norm = ($signed(lead_one(x_r)) - $signed(8'(FRAC_BITS)) + 8'sd1) >>> 1;
      if (k_norm > 8'sd0) begin
         sh_norm = 8'(k_norm <<< 1);
         xn_norm = x_r >> sh_norm;
      end else begin
         sh_norm = 8'((-k_norm) <<< 1);
         xn_norm = x_r << sh_norm;
      end
      wide = '0;
      if (k > 8'sd0) begin
         sh_scale = 8'(k);
         r_scale  = y >> sh_scale;
         sat      = 1'b0;
      end else begin
         sh_scale = 8'(-k);
         wide     = {16'd0, y} << sh_scale;
         sat      = |wide[WIDTH+15:WIDTH];
         r_scale  = sat ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
      end
   end

   // Control FSM, datapath registers and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         x_r       <= '0;
         xn        <= '0;
         y         <= '0;
         t         <= '0;
         k         <= 8'sd0;
         zero      <= 1'b0;
         iter      <= 3'd0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         inv_sqrt  <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_r      <= x;
                  in_ready <= 1'b0;
                  state    <= NORM;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            NORM: begin
               iter <= 3'd0;
               if (x_r == '0) begin
                  zero <= 1'b1;
                  xn   <= FP_ONE;
                  k    <= 8'sd0;
               end else begin
                  zero <= 1'b0;
                  xn   <= xn_norm;
                  k    <= k_norm;
               end
               state <= SEED;
            end
            SEED: begin
               y     <= C0 - mres;
               state <= MUL_SQ;
            end
            MUL_SQ: begin
               t     <= mres;
               state <= MUL_X;
            end
            MUL_X: begin
               t     <= mres;
               state <= MUL_Y;
            end
            MUL_Y: begin
               y <= mres;
               if (iter == LAST_ITER) begin
                  state <= SCALE;
               end else begin
                  iter  <= iter + 3'd1;
                  state <= MUL_SQ;
               end
            end
            SCALE: begin
               // A zero operand forces the saturated code whatever NR produced
               inv_sqrt  <= (zero || sat) ? {WIDTH{1'b1}} : r_scale;
               out_err   <= zero | sat;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sqrt_nr.sv
// Scoreboard bench for inv_sqrt_nr: real-valued model, latency, backpressure,
// throughput and mid-operation reset.
module tb_inv_sqrt_nr;

   localparam int WIDTH = 32;
   localparam int FRAC  = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] x = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] inv_sqrt;
   logic             out_err;

   typedef struct {
      longint val;
      longint tol;
      logic   err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   inv_sqrt_nr #(.WIDTH(WIDTH), .FRAC_BITS(FRAC), .NR_ITERS(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .inv_sqrt(inv_sqrt), .out_err(out_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp, input longint tol);
      longint diff;
      diff = (got > exp) ? got - exp : exp - got;
      n_checks++;
      if (diff > tol) $display("FAIL %s: got 0x%0h expected 0x%0h (tol %0d)", tag, got, exp, tol);
      else n_pass++;
   endtask

   function automatic exp_t model(input logic [31:0] v);
      exp_t e;
      real  r;
      if (v == 32'd0) begin
         e.val = 64'hFFFF_FFFF; e.tol = 64'd0; e.err = 1'b1;
      end else begin
         r = (2.0 ** FRAC) / $sqrt(real'(v) / (2.0 ** FRAC));
         if (r >= 4294967295.0) begin
            e.val = 64'hFFFF_FFFF; e.tol = 64'd0; e.err = 1'b1;
         end else begin
            e.val = longint'(r); e.tol = longint'(r / 4096.0) + 64'd2; e.err = 1'b0;
         end
      end
      return e;
   endfunction

   // Output side of the scoreboard: transfer happens at the next rising edge
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0, 64'd0);
         end else begin
            e = q.pop_front();
            check("inv_sqrt", longint'(inv_sqrt), e.val, e.tol);
            check("out_err", longint'(out_err), longint'(e.err), 64'd0);
         end
      end
   end

   // Called at posedge+2; returns at accept edge+2 with the expectation queued
   task automatic send(input logic [31:0] v, output int acc_cyc);
      int n = 0;
      in_valid = 1'b1;
      x = v;
      while (!in_ready && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1, 64'd0);
      @(posedge clk);
      acc_cyc = cyc;
      q.push_back(model(v));
      #2;
      in_valid = 1'b0;
   endtask

   // Counts edges from the acceptance edge (counted as 1) until out_valid is seen
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #2;
         lat++;
      end
   endtask

   initial begin
      int lat, acc;
      int accs[4];
      logic [31:0] held;
      logic stable;
      logic [31:0] dir[4] = '{32'h0100_0000, 32'h0400_0000, 32'h0040_0000, 32'hFFFF_FFFF};

      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", longint'(out_valid), 64'd0, 64'd0);
      check("rst_inv_sqrt", longint'(inv_sqrt), 64'd0, 64'd0);
      check("rst_out_err", longint'(out_err), 64'd0, 64'd0);
      check("rst_in_ready", longint'(in_ready), 64'd0, 64'd0);
      rst = 1'b0;
      #1;
      check("in_ready_before_edge", longint'(in_ready), 64'd0, 64'd0);
      @(posedge clk); #2;
      check("in_ready_after_release", longint'(in_ready), 64'd1, 64'd0);

      // Directed values, then zero and a saturating tiny input; latency is data independent
      foreach (dir[i]) begin
         send(dir[i], acc);
         wait_out(lat);
         check("latency", longint'(lat), 64'd13, 64'd0);
      end
      send(32'h0000_0000, acc);
      wait_out(lat);
      check("latency_zero", longint'(lat), 64'd13, 64'd0);
      send(32'h0000_0001, acc);
      wait_out(lat);
      check("latency_sat", longint'(lat), 64'd13, 64'd0);

      // Backpressure with a competing input offered during DONE
      @(posedge clk); #2;
      out_ready = 1'b0;
      send(32'h0100_0000, acc);
      wait_out(lat);
      held = inv_sqrt;
      stable = 1'b1;
      in_valid = 1'b1;
      x = 32'h0400_0000;
      repeat (20) begin
         @(posedge clk); #2;
         if (!out_valid || inv_sqrt != held || in_ready) stable = 1'b0;
      end
      check("backpressure_hold", longint'(stable), 64'd1, 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #2;
      check("bp_out_valid_drop", longint'(out_valid), 64'd0, 64'd0);
      check("bp_in_ready_rise", longint'(in_ready), 64'd1, 64'd0);
      send(32'h0400_0000, acc);
      wait_out(lat);

      // Back-to-back throughput with out_ready tied high
      for (int i = 0; i < 4; i++) begin
         send(dir[i], accs[i]);
      end
      for (int i = 0; i < 3; i++) begin
         check("accept_period", longint'(accs[i+1] - accs[i]), 64'd14, 64'd0);
      end
      wait_out(lat);

      // Reset in the middle of an operation drops it
      @(posedge clk); #2;
      send(32'h0100_0000, acc);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_out_valid", longint'(out_valid), 64'd0, 64'd0);
      check("abort_inv_sqrt", longint'(inv_sqrt), 64'd0, 64'd0);
      check("abort_in_ready", longint'(in_ready), 64'd0, 64'd0);
      q.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      stable = 1'b1;
      repeat (20) begin
         @(posedge clk); #2;
         if (out_valid) stable = 1'b0;
      end
      check("abort_no_output", longint'(stable), 64'd1, 64'd0);
      send(32'h0100_0000, acc);
      wait_out(lat);
      check("latency_after_abort", longint'(lat), 64'd13, 64'd0);

      // Random sweep over x in [2^-15, 2^8)
      for (int i = 0; i < 150; i++) begin
         int s;
         logic [31:0] v;
         s = $urandom_range(31, 9);
         v = ($urandom & ((32'd1 << s) - 32'd1)) | (32'd1 << s);
         send(v, acc);
      end
      wait_out(lat);
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", longint'(q.size()), 64'd0, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inv_sqrt_nr.md
# inv_sqrt_nr

Parametrised, handshaked fixed-point inverse square root for the ray marcher's normalisation path (vector normalise, distance-estimator gradients). It replaces the single-shot linear approximation with three stages: even-shift range reduction, a linear seed, and NR_ITERS Newton-Raphson refinements on one shared multiplier. The result is exact-power-of-two rescaled, with saturation and zero detection. It sits between the distance-squared accumulator and the normalise multiplier, using valid/ready on both sides.

## Interface
- WIDTH, 32, data width of x and the result; unsigned fixed point.
- FRAC_BITS, 24, fractional bits (default Q8.24); requires WIDTH-FRAC_BITS ≥ 2.
- NR_ITERS, 3, Newton-Raphson iterations, 1..7.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  x is valid.
- in_ready  out  1  block can accept; high only in IDLE and not in reset.
- x  in  WIDTH  operand, unsigned QWIDTH-FRAC_BITS.FRAC_BITS.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- inv_sqrt  out  WIDTH  1/sqrt(x), same Q format; stable while out_valid.
- out_err  out  1  x was 0, or the result saturated; qualified by out_valid.

## Operation
- FSM states and transitions:
  - IDLE -> NORM on in_valid&in_ready; x is captured on that edge.
  - NORM -> SEED -> (MUL_SQ -> MUL_X -> MUL_Y) × NR_ITERS -> SCALE -> DONE.
  - DONE -> IDLE on out_valid&out_ready.
- NORM:
  - p = index of the leading one of x; d = p - FRAC_BITS; k = floor((d+1)/2), signed.
  - xn = x >> 2k when k>0, x << -2k when k<0, so xn lies in [0.5, 2).
  - x==0: set the zero flag; xn = FP_ONE, k = 0.
- SEED: y = C0 - ((xn*C1) >> FRAC_BITS).
  - C0 = round(1.41421356·2^FRAC_BITS); C1 = round(0.275·2^FRAC_BITS).
  - For Q8.24: C0 = 0x016A09E6, C1 = 0x00466666.
- Each NR iteration uses one WIDTH×WIDTH multiplier with a 2·WIDTH product, taking bits [FRAC_BITS +: WIDTH] (truncation):
  - MUL_SQ: t = y*y.
  - MUL_X: t = t*xn.
  - MUL_Y: y = y*(THREE_HALF - (t>>1)), where THREE_HALF = 1.5·2^FRAC_BITS.
- SCALE (k is exact, no LUT):
  - k>0: r = y >> k.
  - k<0: r = y << -k, computed in WIDTH+16 bits; any bit set above WIDTH-1 -> r = all-ones, sat = 1.
- DONE: inv_sqrt = r, out_err = zero | sat.
- Zero input: inv_sqrt = all-ones (2^WIDTH-1) and out_err = 1, regardless of the NR result.
- Accuracy: for non-saturated x, |inv_sqrt - 1/sqrt(x)| ≤ 2^-12 · 1/sqrt(x) + 2 LSB when NR_ITERS ≥ 3.

## Timing
- Reset values: state = IDLE, out_valid = 0, inv_sqrt = 0, out_err = 0, all internal registers 0. in_ready = 0 while rst is high, then 1 from the first edge after release.
- Latency: out_valid rises 4+3·NR_ITERS edges after the acceptance edge (13 for defaults). The count is data-independent, including x==0.
- Throughput: one operation per 5+3·NR_ITERS cycles when out_ready is held high.
- in_ready falls on the acceptance edge and rises the cycle after out_valid&out_ready. There is no same-cycle accept of a new x in DONE.
- Backpressure: in DONE with out_ready low, inv_sqrt and out_err hold indefinitely. in_valid is ignored while not in IDLE.
- rst mid-operation aborts immediately and returns to the reset values. The operation in flight is dropped; no out_valid is produced for it.
- in_valid and out_ready asserted together in DONE: only the output transfer occurs; the input is accepted next cycle.

## Test plan
- Defaults, x=0x01000000 (1.0) -> 13 cycles later out_valid=1, inv_sqrt=0x01000000 ±0x1002, out_err=0. Then x=0x04000000 (4.0) -> 0x00800000 ±0x802.
- x=0x00400000 (0.25) -> 0x02000000 ±0x2002. x=0xFFFFFFFF (~256) -> 0x00100000 ±0x102.
- x=0 -> inv_sqrt=0xFFFFFFFF, out_err=1, latency still 13. x=0x00000001 (2^-24, true result 4096) -> 0xFFFFFFFF, out_err=1.
- Backpressure: out_ready low for 20 cycles after out_valid -> output stable and in_ready=0 throughout. After the out_ready pulse, in_ready=1 on the next cycle. Back-to-back ops with out_ready tied high -> one accept every 14 cycles.
- rst asserted at cycle 5 of an operation -> out_valid=0, inv_sqrt=0 asynchronously, no result emitted. A new x=0x01000000 afterwards completes correctly.
- Sweep of 10k random x in [2^-16, 2^8) with NR_ITERS=3, plus a WIDTH=24/FRAC_BITS=16 build -> every result within the accuracy bound against a real-valued model.
